// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - command opcodes and run-state encoding for the core clock sequencer
package mips_dbg_pkg;

    localparam logic [2:0] OP_HALT   = 3'b000;
    localparam logic [2:0] OP_RUN    = 3'b001;
    localparam logic [2:0] OP_STEP   = 3'b010;
    localparam logic [2:0] OP_SET_BP = 3'b011;
    localparam logic [2:0] OP_CLR_BP = 3'b100;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_e;

endpackage

// File: rtl/clk_run_ctrl_if.sv
// rtl/clk_run_ctrl_if.sv - debugger command port (valid/ready with opcode and argument)
// Ports carried: cmd_valid, cmd_ready, cmd_op[2:0], cmd_arg[PC_W-1:0].
// master drives the command, slave (the sequencer) returns cmd_ready.
interface clk_run_ctrl_if #(
    parameter int PC_W = 32
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [PC_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/dbg_bp_match.sv
// rtl/dbg_bp_match.sv - breakpoint address/valid registers and PC equality compare
// Ports: clk, rst (async high), set_i/clr_i (load or invalidate breakpoint),
//        addr_i (new breakpoint address), pc_i (current PC), match_o (valid && pc==addr).
module dbg_bp_match #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_i,
    input  logic            clr_i,
    input  logic [PC_W-1:0] addr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            match_o
);
    logic [PC_W-1:0] bp_addr_q;
    logic            bp_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_addr_q  <= '0;
            bp_valid_q <= 1'b0;
        end else if (set_i) begin
            bp_addr_q  <= addr_i;
            bp_valid_q <= 1'b1;
        end else if (clr_i) begin
            bp_valid_q <= 1'b0;
        end
    end

    // Compare uses the registered address, so a SET_BP landing in the same
    // cycle as a hit still sees the previous breakpoint.
    assign match_o = bp_valid_q && (pc_i == bp_addr_q);
endmodule

// File: rtl/clk_run_ctrl.sv
// rtl/clk_run_ctrl.sv - run/halt/step/breakpoint sequencer producing the core clock enable
// Ports: clk, rst (async high), cmd (command port, slave side), pc (PC executed when
//        core_en=1), core_en (clock enable), halted (HALT or BREAK), brk_hit (BREAK),
//        en_cycles (wrapping count of enabled cycles).
module clk_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    clk_run_ctrl_if.slave    cmd,
    input  logic [PC_W-1:0]  pc,
    output logic             core_en,
    output logic             halted,
    output logic             brk_hit,
    output logic [CNT_W-1:0] en_cycles
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] en_cycles_q, en_cycles_d;
    logic             skip_bp_q, skip_bp_d;
    logic             bp_match, bp_hit, accept;
    logic [CNT_W-1:0] step_arg;

    dbg_bp_match #(.PC_W(PC_W)) u_bp (
        .clk     (clk),
        .rst     (rst),
        .set_i   (accept && cmd.cmd_op == OP_SET_BP),
        .clr_i   (accept && cmd.cmd_op == OP_CLR_BP),
        .addr_i  (cmd.cmd_arg),
        .pc_i    (pc),
        .match_o (bp_match)
    );

    // skip_bp masks the breakpoint for the first RUN cycle so a resume from
    // BREAK executes the instruction it stopped on.
    assign bp_hit    = bp_match && (state_q == ST_RUN) && !skip_bp_q;
    assign core_en   = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
    assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
    assign brk_hit   = (state_q == ST_BREAK);
    assign en_cycles = en_cycles_q;

    // Only HALT can interrupt a step sequence.
    assign cmd.cmd_ready = (state_q != ST_STEP) || (cmd.cmd_op == OP_HALT);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign step_arg      = cmd.cmd_arg[CNT_W-1:0];

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        skip_bp_d   = 1'b0;
        en_cycles_d = core_en ? en_cycles_q + CNT_ONE : en_cycles_q;

        case (state_q)
            ST_RUN: begin
                if (bp_hit) state_d = ST_BREAK;
            end
            ST_STEP: begin
                step_cnt_d = step_cnt_q - CNT_ONE;
                if (step_cnt_q == CNT_ONE) state_d = ST_HALT;
            end
            default: ;
        endcase

        // State-changing commands override breakpoint and step completion.
        if (accept) begin
            case (cmd.cmd_op)
                OP_HALT: state_d = ST_HALT;
                OP_RUN: begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end
                OP_STEP: begin
                    state_d    = ST_STEP;
                    step_cnt_d = (step_arg == '0) ? CNT_ONE : step_arg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            step_cnt_q  <= '0;
            skip_bp_q   <= 1'b0;
            en_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            skip_bp_q   <= skip_bp_d;
            en_cycles_q <= en_cycles_d;
        end
    end
endmodule

// File: tb/tb_clk_run_ctrl.sv
// tb/tb_clk_run_ctrl.sv - self-checking bench for clk_run_ctrl
module tb_clk_run_ctrl;
    import mips_dbg_pkg::*;

    localparam logic [2:0] NOP = 3'b111;

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  op;
        logic [31:0] arg;
        logic [31:0] pc;
        logic        en;
        logic        rdy;
        logic        hlt;
        logic        brk;
        logic [3:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc  = '0;
    logic        core_en, halted, brk_hit;
    logic [3:0]  en_cycles;

    int checks   = 0;
    int failures = 0;
    int row      = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    clk_run_ctrl_if #(.PC_W(32)) ifc ();

    clk_run_ctrl #(.PC_W(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (ifc.slave),
        .pc        (pc),
        .core_en   (core_en),
        .halted    (halted),
        .brk_hit   (brk_hit),
        .en_cycles (en_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] op,
                                input logic [31:0] arg, input logic [31:0] p,
                                input logic en, input logic rdy, input logic hlt,
                                input logic brk, input logic [3:0] cnt);
        vec_t x;
        x.rst = r; x.v = v; x.op = op; x.arg = arg; x.pc = p;
        x.en = en; x.rdy = rdy; x.hlt = hlt; x.brk = brk; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL row%0d %s got=%0h expected=%0h", row, name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, queue its expectation, then
    // compare the combinational/registered outputs before the next rising edge.
    task automatic cyc(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        ifc.cmd_valid = v.v;
        ifc.cmd_op    = v.op;
        ifc.cmd_arg   = v.arg;
        pc            = v.pc;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        chk("core_en",   int'(core_en),       int'(e.en));
        chk("cmd_ready", int'(ifc.cmd_ready), int'(e.rdy));
        chk("halted",    int'(halted),        int'(e.hlt));
        chk("brk_hit",   int'(brk_hit),       int'(e.brk));
        chk("en_cycles", int'(en_cycles),     int'(e.cnt));
        row++;
    endtask

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = NOP;
        ifc.cmd_arg   = '0;

        // Reset and idle
        tbl.push_back(mk(1,0,NOP,0,0, 0,1,1,0,0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,NOP,0,0, 0,1,1,0,0));
        // STEP 3, then STEP 0 (treated as 1)
        tbl.push_back(mk(0,1,OP_STEP,3,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0,NOP,0,0,     1,0,0,0,0));
        tbl.push_back(mk(0,0,NOP,0,0,     1,0,0,0,1));
        tbl.push_back(mk(0,0,NOP,0,0,     1,0,0,0,2));
        tbl.push_back(mk(0,0,NOP,0,0,     0,1,1,0,3));
        tbl.push_back(mk(0,1,OP_STEP,0,0, 0,1,1,0,3));
        tbl.push_back(mk(0,0,NOP,0,0,     1,0,0,0,3));
        tbl.push_back(mk(0,0,NOP,0,0,     0,1,1,0,4));
        // Breakpoint at 0x40 with a PC ramp
        tbl.push_back(mk(1,0,NOP,0,0,           0,1,1,0,0));
        tbl.push_back(mk(0,1,OP_SET_BP,32'h40,0, 0,1,1,0,0));
        tbl.push_back(mk(0,1,OP_RUN,0,0,        0,1,1,0,0));
        tbl.push_back(mk(0,0,NOP,0,32'h30,      1,1,0,0,0));
        tbl.push_back(mk(0,0,NOP,0,32'h34,      1,1,0,0,1));
        tbl.push_back(mk(0,0,NOP,0,32'h38,      1,1,0,0,2));
        tbl.push_back(mk(0,0,NOP,0,32'h3c,      1,1,0,0,3));
        tbl.push_back(mk(0,0,NOP,0,32'h40,      0,1,0,0,4));
        tbl.push_back(mk(0,0,NOP,0,32'h40,      0,1,1,1,4));
        // Resume from BREAK, clear breakpoint, pass 0x40 again
        tbl.push_back(mk(0,1,OP_RUN,0,32'h40,    0,1,1,1,4));
        tbl.push_back(mk(0,0,NOP,0,32'h40,       1,1,0,0,4));
        tbl.push_back(mk(0,0,NOP,0,32'h44,       1,1,0,0,5));
        tbl.push_back(mk(0,1,OP_CLR_BP,0,32'h48, 1,1,0,0,6));
        tbl.push_back(mk(0,0,NOP,0,32'h40,       1,1,0,0,7));
        tbl.push_back(mk(0,0,NOP,0,32'h44,       1,1,0,0,8));
        tbl.push_back(mk(0,1,OP_HALT,0,32'h48,   1,1,0,0,9));
        tbl.push_back(mk(0,0,NOP,0,32'h4c,       0,1,1,0,10));

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

        // RUN accepted in the same cycle as a breakpoint hit stays in RUN
        cyc(mk(1,0,NOP,0,0,            0,1,1,0,0));
        cyc(mk(0,1,OP_SET_BP,32'h40,0, 0,1,1,0,0));
        cyc(mk(0,1,OP_RUN,0,0,         0,1,1,0,0));
        cyc(mk(0,0,NOP,0,32'h3c,       1,1,0,0,0));
        cyc(mk(0,1,OP_RUN,0,32'h40,    0,1,0,0,1));
        cyc(mk(0,0,NOP,0,32'h40,       1,1,0,0,1));
        cyc(mk(0,0,NOP,0,32'h40,       0,1,0,0,2));
        cyc(mk(0,0,NOP,0,32'h40,       0,1,1,1,2));

        // STEP 10 interrupted: RUN refused, HALT accepted on the fourth step cycle
        cyc(mk(1,0,NOP,0,0,        0,1,1,0,0));
        cyc(mk(0,1,OP_STEP,10,0,   0,1,1,0,0));
        cyc(mk(0,0,NOP,0,0,        1,0,0,0,0));
        cyc(mk(0,1,OP_RUN,0,0,     1,0,0,0,1));
        cyc(mk(0,1,OP_RUN,0,0,     1,0,0,0,2));
        cyc(mk(0,1,OP_HALT,0,0,    1,1,0,0,3));
        cyc(mk(0,0,NOP,0,0,        0,1,1,0,4));
        cyc(mk(0,0,NOP,0,0,        0,1,1,0,4));

        // Long RUN wraps the 4-bit counter 15 -> 0, then reset mid-RUN
        cyc(mk(1,0,NOP,0,0,    0,1,1,0,0));
        cyc(mk(0,1,OP_RUN,0,0, 0,1,1,0,0));
        for (int i = 0; i <= 16; i++) begin
            logic [3:0] c;
            c = 4'(i);
            cyc(mk(0,0,NOP,0,32'(i*4), 1,1,0,0,c));
        end
        cyc(mk(1,0,NOP,0,0, 0,1,1,0,0));
        cyc(mk(0,0,NOP,0,0, 0,1,1,0,0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
